// File: rtl/cpu_register_file_multiport.sv
// -----------------------------------------------------------------------------
// cpu_register_file_multiport
//
// Parametrised multi-port CPU register file with a hardware bulk-clear
// sequencer.
//   - NUM_READ_PORTS combinational (zero-latency) read ports.
//   - NUM_WRITE_PORTS write ports. When several ports write the same address
//     in one cycle, the highest-index enabled port wins.
//   - Register 0 is hardwired to zero.
//   - The bulk-clear sequencer (IDLE -> CLEAR -> DONE) zeroes registers
//     1..NUMBER_OF_REGISTERS-1, one per cycle. Write ports are ignored while
//     it runs, and clear_done_out pulses for one cycle when it finishes.
//
// Optional build macro:
//   RF_WRITE_BYPASS_EN - write-to-read forwarding. A read of an address that
//                        is being written this cycle returns the winning
//                        write data combinationally. There is no forwarding
//                        for address 0 or while clearing.
//
// Ports:
//   clock_in                   clock, all state changes on posedge
//   reset_in                   asynchronous active-high reset
//   write_enable_in            [NUM_WRITE_PORTS] per-port write strobe
//   write_register_address_in  [NUM_WRITE_PORTS*ADDR_W] packed per port
//   write_data_in              [NUM_WRITE_PORTS*DATA_WIDTH] packed per port
//   read_register_address_in   [NUM_READ_PORTS*ADDR_W] packed per port
//   read_data_out              [NUM_READ_PORTS*DATA_WIDTH] packed per port
//   clear_request_in           start bulk clear (sampled in IDLE only)
//   clear_busy_out             high while clearing
//   clear_done_out             one-cycle pulse on clear completion
// -----------------------------------------------------------------------------

// One read port: register lookup plus optional forwarding from the write ports.
module cpu_register_file_multiport_rd_port #(
    parameter int NUMBER_OF_REGISTERS = 256,
    parameter int DATA_WIDTH          = 8,
    parameter int NUM_WRITE_PORTS     = 2,
    parameter int ADDR_W              = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic [NUMBER_OF_REGISTERS-1:0][DATA_WIDTH-1:0] regs_in,
    input  logic [ADDR_W-1:0]                              rd_addr_in,
    input  logic [NUM_WRITE_PORTS-1:0]                     wr_en_in,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]         wr_addr_in,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0]     wr_data_in,
    input  logic                                           clearing_in,
    output logic [DATA_WIDTH-1:0]                          rd_data_out
);
`ifdef RF_WRITE_BYPASS_EN
    always_comb begin
        rd_data_out = regs_in[rd_addr_in];
        if (!clearing_in && rd_addr_in != '0) begin
            // Ascending scan: the last match is the highest-index port.
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (wr_en_in[p] && wr_addr_in[p] == rd_addr_in) begin
                    rd_data_out = wr_data_in[p];
                end
            end
        end
    end
`else
    // Without forwarding the write ports are not looked at; the new value
    // becomes visible the cycle after the write edge.
    logic unused_fwd;
    assign unused_fwd  = ^{wr_en_in, wr_addr_in, wr_data_in, clearing_in};
    assign rd_data_out = regs_in[rd_addr_in];
`endif
endmodule

module cpu_register_file_multiport #(
    parameter int NUMBER_OF_REGISTERS = 256,
    parameter int DATA_WIDTH          = 8,
    parameter int NUM_READ_PORTS      = 2,
    parameter int NUM_WRITE_PORTS     = 2,
    parameter int ADDR_W              = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                 clock_in,
    input  logic                                 reset_in,
    input  logic [NUM_WRITE_PORTS-1:0]           write_enable_in,
    input  logic [NUM_WRITE_PORTS*ADDR_W-1:0]    write_register_address_in,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data_in,
    input  logic [NUM_READ_PORTS*ADDR_W-1:0]     read_register_address_in,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_out,
    input  logic                                 clear_request_in,
    output logic                                 clear_busy_out,
    output logic                                 clear_done_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMBER_OF_REGISTERS - 1);

    state_t                                         state_q, state_d;
    logic [ADDR_W-1:0]                              counter_q, counter_d;
    logic [NUMBER_OF_REGISTERS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    // Unpacked per-port views of the flat write buses.
    logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0]     wr_addr;
    logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data;

    for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_wr_unpack
        assign wr_addr[p] = write_register_address_in[p*ADDR_W +: ADDR_W];
        assign wr_data[p] = write_data_in[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            IDLE: begin
                if (clear_request_in) begin
                    state_d   = CLEAR;
                    counter_d = ADDR_W'(1);
                end
            end
            CLEAR: begin
                // Stop on the last entry instead of incrementing, so the
                // counter never wraps.
                if (counter_q == LAST_ADDR) begin
                    state_d   = DONE;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    assign clear_busy_out = (state_q == CLEAR);
    assign clear_done_out = (state_q == DONE);

    // ------------------------------------------------------------------
    // Register array update
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (state_q == CLEAR) begin
            regs_d[counter_q] = '0;
        end else begin
            // Ascending port order: later assignments override earlier ones,
            // so the highest-index enabled port wins on an address conflict.
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (write_enable_in[p] && wr_addr[p] != '0) begin
                    regs_d[wr_addr[p]] = wr_data[p];
                end
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
        cpu_register_file_multiport_rd_port #(
            .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
            .DATA_WIDTH          (DATA_WIDTH),
            .NUM_WRITE_PORTS     (NUM_WRITE_PORTS),
            .ADDR_W              (ADDR_W)
        ) u_rd (
            .regs_in     (regs_q),
            .rd_addr_in  (read_register_address_in[r*ADDR_W +: ADDR_W]),
            .wr_en_in    (write_enable_in),
            .wr_addr_in  (wr_addr),
            .wr_data_in  (wr_data),
            .clearing_in (clear_busy_out),
            .rd_data_out (read_data_out[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_cpu_register_file_multiport.sv
// -----------------------------------------------------------------------------
// tb_cpu_register_file_multiport
//
// Directed self-checking bench for cpu_register_file_multiport with the
// default configuration (256 x 8, 2 read ports, 2 write ports).
// Inputs change 1 ns after each rising edge; outputs are checked after a
// further 1 ns settle.
// -----------------------------------------------------------------------------
module tb_cpu_register_file_multiport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  we = '0;
    logic [15:0] waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] raddr = '0;
    logic [15:0] rdata;
    logic        req = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_register_file_multiport dut (
        .clock_in                  (clk),
        .reset_in                  (rst),
        .write_enable_in           (we),
        .write_register_address_in (waddr),
        .write_data_in             (wdata),
        .read_register_address_in  (raddr),
        .read_data_out             (rdata),
        .clear_request_in          (req),
        .clear_busy_out            (busy),
        .clear_done_out            (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [7:0] a, input logic [7:0] d);
        we[p]          = en;
        waddr[p*8 +: 8] = a;
        wdata[p*8 +: 8] = d;
    endtask

    task automatic set_rd(input int p, input logic [7:0] a);
        raddr[p*8 +: 8] = a;
    endtask

    task automatic test_reset();
        logic [7:0] got0, got1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", busy, done);
        end
        for (int a = 0; a < 256; a++) begin
            set_rd(0, 8'(a));
            set_rd(1, 8'(255 - a));
            #1;
            got0 = rdata[7:0];
            got1 = rdata[15:8];
            checks++;
            if (got0 !== 8'h00 || got1 !== 8'h00) begin
                failures++;
                $display("FAIL reset_read addr=%0d got p0=%h p1=%h required 00", a, got0, got1);
            end
        end
        step();
        rst = 1'b0;
        step();
        // Write a value, then assert reset between edges: output must drop at once.
        set_wr(0, 1'b1, 8'd10, 8'h5A);
        step();
        set_wr(0, 1'b0, 8'd0, 8'h00);
        set_rd(0, 8'd10);
        set_rd(1, 8'd10);
        #1;
        checks++;
        if (rdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL pre_async_reset got=%h required 5a5a", rdata);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset_read got=%h required 0000", rdata);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_write();
        set_wr(0, 1'b1, 8'd5, 8'hA5);
        step();
        set_wr(0, 1'b0, 8'd0, 8'h00);
        set_rd(0, 8'd5);
        set_rd(1, 8'd5);
        #1;
        checks++;
        if (rdata !== 16'hA5A5) begin
            failures++;
            $display("FAIL write_r5 got=%h required a5a5", rdata);
        end
        set_wr(1, 1'b1, 8'd0, 8'hFF);
        step();
        set_wr(1, 1'b0, 8'd0, 8'h00);
        set_rd(0, 8'd0);
        set_rd(1, 8'd0);
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            failures++;
            $display("FAIL write_r0 got=%h required 0000", rdata);
        end
    endtask

    task automatic test_conflict();
        set_wr(0, 1'b1, 8'd9, 8'h11);
        set_wr(1, 1'b1, 8'd9, 8'h22);
        step();
        set_wr(0, 1'b1, 8'd3, 8'h33);
        set_wr(1, 1'b1, 8'd4, 8'h44);
        set_rd(0, 8'd9);
        set_rd(1, 8'd9);
        #1;
        checks++;
        if (rdata !== 16'h2222) begin
            failures++;
            $display("FAIL conflict_r9 got=%h required 2222", rdata);
        end
        step();
        set_wr(0, 1'b0, 8'd0, 8'h00);
        set_wr(1, 1'b0, 8'd0, 8'h00);
        set_rd(0, 8'd3);
        set_rd(1, 8'd4);
        #1;
        checks++;
        if (rdata !== 16'h4433) begin
            failures++;
            $display("FAIL dual_write_r3_r4 got=%h required 4433", rdata);
        end
    endtask

    task automatic fill_index();
        for (int i = 1; i < 256; i += 2) begin
            set_wr(0, 1'b1, 8'(i), 8'(i));
            set_wr(1, (i + 1) < 256, 8'(i + 1), 8'(i + 1));
            step();
        end
        set_wr(0, 1'b0, 8'd0, 8'h00);
        set_wr(1, 1'b0, 8'd0, 8'h00);
    endtask

    task automatic test_clear();
        int busy_cycles;
        logic [7:0] got0, got1;
        fill_index();
        set_rd(0, 8'd77);
        set_rd(1, 8'd255);
        #1;
        checks++;
        if (rdata !== {8'd255, 8'd77}) begin
            failures++;
            $display("FAIL fill_read got=%h required ff4d", rdata);
        end
        req = 1'b1;
        step();
        req = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 400) begin
            busy_cycles++;
            // Counter equals busy_cycles here; entries below it are cleared.
            if (busy_cycles == 50) begin
                set_wr(0, 1'b1, 8'd2, 8'h77);
                set_wr(1, 1'b1, 8'd250, 8'h55);
            end else begin
                set_wr(0, 1'b0, 8'd0, 8'h00);
                set_wr(1, 1'b0, 8'd0, 8'h00);
            end
            if (busy_cycles == 100) begin
                set_rd(0, 8'd99);
                set_rd(1, 8'd100);
                #1;
                checks++;
                if (rdata !== {8'd100, 8'd0}) begin
                    failures++;
                    $display("FAIL mid_clear_read got=%h required 6400", rdata);
                end
                set_rd(0, 8'd2);
                set_rd(1, 8'd250);
                #1;
                checks++;
                if (rdata !== {8'd250, 8'd0}) begin
                    failures++;
                    $display("FAIL write_during_clear got=%h required fa00", rdata);
                end
            end
            step();
        end
        checks++;
        if (busy_cycles !== 255) begin
            failures++;
            $display("FAIL clear_busy_cycles got=%0d required 255", busy_cycles);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_done_pulse done=%b busy=%b required done=1 busy=0", done, busy);
        end
        // A request seen in DONE is ignored.
        req = 1'b1;
        step();
        req = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_width done=%b busy=%b required done=0 busy=0", done, busy);
        end
        for (int a = 0; a < 256; a++) begin
            set_rd(0, 8'(a));
            set_rd(1, 8'(255 - a));
            #1;
            got0 = rdata[7:0];
            got1 = rdata[15:8];
            checks++;
            if (got0 !== 8'h00 || got1 !== 8'h00) begin
                failures++;
                $display("FAIL post_clear_read addr=%0d got p0=%h p1=%h required 00", a, got0, got1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        int done_seen;
        set_wr(0, 1'b1, 8'd150, 8'hCD);
        set_wr(1, 1'b1, 8'd250, 8'hAB);
        step();
        set_wr(0, 1'b0, 8'd0, 8'h00);
        set_wr(1, 1'b0, 8'd0, 8'h00);
        req = 1'b1;
        step();
        req = 1'b0;
        busy_cycles = 1;
        while (busy === 1'b1 && busy_cycles < 100) begin
            step();
            busy_cycles++;
        end
        checks++;
        if (busy !== 1'b1 || busy_cycles !== 100) begin
            failures++;
            $display("FAIL reach_counter_100 busy=%b cycles=%0d required busy=1 cycles=100", busy, busy_cycles);
        end
        set_rd(0, 8'd150);
        set_rd(1, 8'd250);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_clear busy=%b done=%b rd=%h required 0 0 0000", busy, done, rdata);
        end
        #3;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL no_done_after_reset got=%0d active cycles required 0", done_seen);
        end
        req = 1'b1;
        step();
        req = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 400) begin
            busy_cycles++;
            step();
        end
        checks++;
        if (busy_cycles !== 255 || done !== 1'b1) begin
            failures++;
            $display("FAIL clear_after_reset cycles=%0d done=%b required 255 1", busy_cycles, done);
        end
        step();
    endtask

    task automatic test_bypass();
        set_wr(0, 1'b1, 8'd7, 8'h11);
        step();
        set_wr(0, 1'b1, 8'd7, 8'h3C);
        set_rd(0, 8'd7);
        set_rd(1, 8'd7);
        #1;
        checks++;
`ifdef RF_WRITE_BYPASS_EN
        if (rdata !== 16'h3C3C) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h required 3c3c", rdata);
        end
`else
        if (rdata !== 16'h1111) begin
            failures++;
            $display("FAIL no_bypass_same_cycle got=%h required 1111", rdata);
        end
`endif
        step();
        set_wr(0, 1'b0, 8'd0, 8'h00);
        #1;
        checks++;
        if (rdata !== 16'h3C3C) begin
            failures++;
            $display("FAIL write_next_cycle got=%h required 3c3c", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_conflict();
        test_clear();
        test_reset_mid_clear();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_register_file_multiport.md
Name: cpu_register_file_multiport

Overview:
- Parametrised successor to the CPU register file.
- Adds configurable data width and depth, NUM_READ_PORTS combinational read ports and NUM_WRITE_PORTS write ports, with fixed write-conflict priority.
- Adds a hardware bulk-clear sequencer with a busy/done handshake, used by the CPU control unit to zero architectural state between tensor kernels without a full reset.

Parameters:
- NUMBER_OF_REGISTERS, 256, register count (power of two, >= 4); ADDR_W = $clog2(NUMBER_OF_REGISTERS)
- DATA_WIDTH, 8, bits per register
- NUM_READ_PORTS, 2, independent combinational read ports (>= 1)
- NUM_WRITE_PORTS, 2, independent write ports (>= 1)

Ports:
- clock_in  in  1  single clock; all state updates on posedge
- reset_in  in  1  asynchronous, active-high reset
- write_enable_in  in  NUM_WRITE_PORTS  per-port write strobe
- write_register_address_in  in  NUM_WRITE_PORTS*ADDR_W  packed; port p at [p*ADDR_W +: ADDR_W]
- write_data_in  in  NUM_WRITE_PORTS*DATA_WIDTH  packed per port
- read_register_address_in  in  NUM_READ_PORTS*ADDR_W  packed per port
- read_data_out  out  NUM_READ_PORTS*DATA_WIDTH  packed per port
- clear_request_in  in  1  start bulk clear (level or pulse, sampled in IDLE only)
- clear_busy_out  out  1  high while the sequencer is in CLEAR
- clear_done_out  out  1  single-cycle pulse when the clear completes

Behaviour:
- Reset (asynchronous, immediate on reset_in high):
  - all registers = 0; FSM = IDLE; clear counter = 0
  - clear_busy_out = 0, clear_done_out = 0
  - read_data_out = 0, since contents are zero
- Register 0 is hardwired zero. Writes to address 0 are discarded; reads of address 0 always return 0.
- Reads are combinational, zero latency: read_data_out[p] = registers[read addr p]. No read-port conflicts exist; all ports may read the same address.
- Writes commit on posedge when write_enable_in[p]=1 and address != 0.
- Same-address conflict in one cycle: highest-index enabled port wins; lower ports are dropped for that address.
- FSM states IDLE, CLEAR, DONE:
  - IDLE: clear_request_in=1 -> CLEAR; counter loads 1.
  - CLEAR: each cycle registers[counter] = 0, counter++. When counter = NUMBER_OF_REGISTERS-1 is cleared -> DONE. CLEAR lasts NUMBER_OF_REGISTERS-1 cycles; clear_busy_out=1 throughout.
  - DONE: clear_done_out=1 for exactly one cycle; clear_busy_out=0 -> IDLE. A request seen in DONE is ignored.
- While CLEAR: all write ports are ignored, regardless of address. Reads return current contents; already-cleared entries read 0, uncleared entries read old values. clear_request_in is ignored.
- Write in the same cycle as the IDLE->CLEAR transition: the write commits. The clear later overwrites it.
- reset_in asserted mid-CLEAR: immediate return to IDLE with all registers 0. No done pulse.
- Counter width ADDR_W. It never wraps, because the transition to DONE occurs before overflow.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: write-to-read forwarding. If a read address equals an address being validly written this cycle, read_data_out returns the winning write_data_in combinationally, using the same priority rule.
  - No forwarding for address 0.
  - No forwarding while clear_busy_out=1.
- Undefined: reads return pre-edge register contents; the new value is visible the cycle after the edge.

Test Plan:
- Reset then read all 256 addresses on both ports -> all 0. Assert reset_in mid-cycle -> outputs drop to 0 without waiting for a clock edge.
- Port0 writes 0xA5 to r5; next cycle read r5 on both ports -> 0xA5. Write 0xFF to r0 -> r0 reads 0.
- Same cycle: port0 writes 0x11 to r9, port1 writes 0x22 to r9 -> r9 = 0x22. Ports 0/1 writing r3/r4 simultaneously -> both commit.
- Fill r1..r255 with the index value. Pulse clear_request_in -> busy high for 255 cycles, then done high for exactly 1 cycle. All registers read 0. Writes during busy are discarded.
- Reset asserted at clear counter = 100 -> busy=0 immediately, no done pulse, all registers 0. A new request then completes normally.
- With RF_WRITE_BYPASS_EN: write 0x3C to r7 while reading r7 -> read_data_out = 0x3C in the same cycle. Without the macro -> old value, then 0x3C on the next cycle.
